// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: FSM state encoding, Clause-22 frame codes and frame geometry.
// Used by both the MDIO controller and the PHY-side peripheral.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WTA,
    WDATA,
    RTA,
    RDATA,
    SKIP
  } mdio_state_e;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] ST_CODE    = 2'b01;
  localparam int         FRAME_BITS = 32;
  localparam int         HDR_LAST   = 13;

endpackage

// File: rtl/mdc_edge_det.sv
// Oversampled MDC edge detector: one-cycle rise/fall pulses in the clk domain.
module mdc_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_q <= 1'b0;
    end else begin
      mdc_q <= mdc;
    end
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side Clause-22 MDIO slave: decodes write/read frames from an oversampled MDC,
// drives a register-memory port and serialises read data back to the controller.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic        mdio_in_oe,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [15:0] rd_data
);

  // bit_cnt holds the index of the next bit to be sampled
  localparam logic [4:0] CNT_HDR  = 5'(HDR_LAST);
  localparam logic [4:0] CNT_TA1  = 5'(HDR_LAST + 2);
  localparam logic [4:0] CNT_DATA = 5'(HDR_LAST + 3);
  localparam logic [4:0] CNT_LAST = 5'(FRAME_BITS - 1);

  logic rise;
  logic fall;

  mdc_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .mdc   (mdc),
    .rise  (rise),
    .fall  (fall)
  );

  mdio_state_e state_reg, state_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [10:0] hdr_sr_reg, hdr_sr_next;
  logic [14:0] data_sr_reg, data_sr_next;
  logic [15:0] rd_sr_reg, rd_sr_next;
  logic        rd_lat_reg;
  logic [4:0]  addr_reg, addr_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic        mem_wr_reg, mem_wr_next;
  logic        mem_rd_reg, mem_rd_next;
  logic        mdio_in_reg, mdio_in_next;
  logic        mdio_in_oe_reg, mdio_in_oe_next;

  // Header bits 2..13 including the bit currently on the wire
  logic [11:0] hdr_word;
  logic [1:0]  op_f;
  logic [4:0]  phy_f;
  logic [4:0]  regad_f;
  logic [15:0] data_word;

  assign hdr_word  = {hdr_sr_reg, mdio_out};
  assign op_f      = hdr_word[11:10];
  assign phy_f     = hdr_word[9:5];
  assign regad_f   = hdr_word[4:0];
  assign data_word = {data_sr_reg, mdio_out};

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    hdr_sr_next     = hdr_sr_reg;
    data_sr_next    = data_sr_reg;
    rd_sr_next      = rd_sr_reg;
    addr_next       = addr_reg;
    wr_data_next    = wr_data_reg;
    mem_wr_next     = 1'b0;
    mem_rd_next     = 1'b0;
    mdio_in_next    = mdio_in_reg;
    mdio_in_oe_next = mdio_in_oe_reg;

    if (rd_lat_reg) begin
      rd_sr_next = rd_data;
    end

    unique case (state_reg)
      IDLE: begin
        if (rise && mdio_oe && (mdio_out == ST_CODE[1])) begin
          state_next   = HDR;
          bit_cnt_next = 5'd1;
        end
      end

      HDR: begin
        if (rise) begin
          bit_cnt_next = bit_cnt_reg + 5'd1;
          hdr_sr_next  = hdr_word[10:0];
          if (!mdio_oe || ((bit_cnt_reg == 5'd1) && (mdio_out != ST_CODE[0]))) begin
            state_next   = IDLE;
            bit_cnt_next = 5'd0;
          end else if (bit_cnt_reg == CNT_HDR) begin
            if ((phy_f == PHY_ADDR) && (op_f == OP_WRITE)) begin
              addr_next  = regad_f;
              state_next = WTA;
            end else if ((phy_f == PHY_ADDR) && (op_f == OP_READ)) begin
              addr_next   = regad_f;
              mem_rd_next = 1'b1;
              state_next  = RTA;
            end else begin
              state_next = SKIP;
            end
          end
        end
      end

      WTA: begin
        if (rise) begin
          bit_cnt_next = bit_cnt_reg + 5'd1;
          if (!mdio_oe) begin
            state_next   = IDLE;
            bit_cnt_next = 5'd0;
          end else if (bit_cnt_reg == CNT_TA1) begin
            state_next = WDATA;
          end
        end
      end

      WDATA: begin
        if (rise) begin
          bit_cnt_next = bit_cnt_reg + 5'd1;
          data_sr_next = data_word[14:0];
          if (!mdio_oe) begin
            state_next   = IDLE;
            bit_cnt_next = 5'd0;
          end else if (bit_cnt_reg == CNT_LAST) begin
            wr_data_next = data_word;
            mem_wr_next  = 1'b1;
            state_next   = IDLE;
            bit_cnt_next = 5'd0;
          end
        end
      end

      RTA: begin
        if (rise) begin
          bit_cnt_next = bit_cnt_reg + 5'd1;
        end else if (fall) begin
          if (bit_cnt_reg == CNT_TA1) begin
            mdio_in_oe_next = 1'b1;
            mdio_in_next    = 1'b0;
          end else if (bit_cnt_reg == CNT_DATA) begin
            mdio_in_next = rd_sr_reg[15];
            rd_sr_next   = {rd_sr_reg[14:0], 1'b0};
            state_next   = RDATA;
          end
        end
      end

      RDATA: begin
        // bit_cnt wraps to 0 on the rise of bit 31, marking the end of the frame
        if (rise) begin
          bit_cnt_next = bit_cnt_reg + 5'd1;
        end else if (fall) begin
          if (bit_cnt_reg == 5'd0) begin
            mdio_in_oe_next = 1'b0;
            mdio_in_next    = 1'b0;
            state_next      = IDLE;
          end else begin
            mdio_in_next = rd_sr_reg[15];
            rd_sr_next   = {rd_sr_reg[14:0], 1'b0};
          end
        end
      end

      SKIP: begin
        if (rise) begin
          if (bit_cnt_reg == CNT_LAST) begin
            state_next   = IDLE;
            bit_cnt_next = 5'd0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 5'd1;
          end
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 5'd0;
      hdr_sr_reg     <= '0;
      data_sr_reg    <= '0;
      rd_sr_reg      <= '0;
      rd_lat_reg     <= 1'b0;
      addr_reg       <= '0;
      wr_data_reg    <= '0;
      mem_wr_reg     <= 1'b0;
      mem_rd_reg     <= 1'b0;
      mdio_in_reg    <= 1'b0;
      mdio_in_oe_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      hdr_sr_reg     <= hdr_sr_next;
      data_sr_reg    <= data_sr_next;
      rd_sr_reg      <= rd_sr_next;
      rd_lat_reg     <= mem_rd_reg;
      addr_reg       <= addr_next;
      wr_data_reg    <= wr_data_next;
      mem_wr_reg     <= mem_wr_next;
      mem_rd_reg     <= mem_rd_next;
      mdio_in_reg    <= mdio_in_next;
      mdio_in_oe_reg <= mdio_in_oe_next;
    end
  end

  assign mdio_in    = mdio_in_reg;
  assign mdio_in_oe = mdio_in_oe_reg;
  assign addr       = addr_reg;
  assign wr_data    = wr_data_reg;
  assign mem_wr     = mem_wr_reg;
  assign mem_rd     = mem_rd_reg;

endmodule

// File: doc/mdio_peripheral.md
# mdio_peripheral

PHY-side MDIO slave, directly downstream of the MDIO controller. It receives the controller's MDC/MDIO serial frames, decodes Clause-22 write and read transactions, and drives a simple register-memory port. For reads it serialises the returned 16-bit word back to the controller. Everything runs in the controller's `clk` domain, so MDC is oversampled rather than used as a clock.

## Interface
- `PHY_ADDR`, default 5'd0: PHY address this block answers to.
- `clk`  in  1: system clock. The same clock the controller uses to generate MDC.
- `reset`  in  1: synchronous, active-high reset.
- `mdc`  in  1: management clock from the controller. High and low phases are each ≥2 `clk` cycles.
- `mdio_out`  in  1: serial data driven by the controller.
- `mdio_oe`  in  1: controller output-enable; high while the controller drives `mdio_out`.
- `mdio_in`  out  1: serial read data returned to the controller.
- `mdio_in_oe`  out  1: high while this block drives `mdio_in`.
- `addr`  out  5: register address (REGAD) for the memory port.
- `wr_data`  out  16: write data for the memory port.
- `mem_wr`  out  1: one-cycle write strobe.
- `mem_rd`  out  1: one-cycle read strobe.
- `rd_data`  in  16: memory read data. Valid exactly 1 `clk` after `mem_rd`.

## Operation
- Frame format, MSB first, 32 bits, no preamble required:
  - ST = 01
  - OP = 01 (write) or 10 (read)
  - PHYAD[4:0]
  - REGAD[4:0]
  - TA[1:0]
  - DATA[15:0]
- Edge detection: `mdc_q` is a 1-flop delay of `mdc`.
  - `rise = mdc & ~mdc_q`
  - `fall = ~mdc & mdc_q`
  - `mdio_out` is sampled only in `rise` cycles.
- Bit counter `bit_cnt` is 5 bits. It increments on each `rise` after frame start; bit index 0 is the first ST bit.
- FSM states and transitions:
  - IDLE: on `rise` with `mdio_oe`=1 and `mdio_out`=0 (ST bit 0), go to HDR with `bit_cnt`=1.
  - HDR: shift bits 1..13.
    - At bit 1, if the bit ≠1 (bad ST), return to IDLE.
    - At bit 13, evaluate the header:
      - OP=01 and PHYAD==`PHY_ADDR`: latch `addr`, go to WTA.
      - OP=10 and PHYAD==`PHY_ADDR`: latch `addr`, pulse `mem_rd`, go to RTA.
      - Otherwise (OP=00/11 or address mismatch): go to SKIP.
  - WTA: consume bits 14–15 (TA, values ignored), then go to WDATA.
  - WDATA: shift bits 16–31 into `wr_data`. After bit 31, pulse `mem_wr` and go to IDLE.
  - RTA: latch `rd_data` into the read shift register 1 cycle after `mem_rd`.
    - Bit 14: `mdio_in_oe`=0.
    - On the `fall` following bit 14: assert `mdio_in_oe`=1 with `mdio_in`=0 (TA low bit).
    - On the next `fall`: present DATA[15]; go to RDATA.
  - RDATA: on each `fall`, present the next bit, through DATA[0]. On the `fall` after bit 31, drop `mdio_in_oe` and `mdio_in` to 0 and go to IDLE.
  - SKIP: count `rise` edges to bit 31 without any strobe or drive, then go to IDLE.
- Abort conditions:
  - `mdio_oe` low on a `rise` in HDR, WTA or WDATA: go to IDLE; no `mem_wr`.
  - `mdio_oe` high in RTA/RDATA: ignored.
- `mem_wr` and `mem_rd` are never high in the same cycle. Each fires at most once per frame.

## Timing
- Reset values:
  - `mdio_in`=0, `mdio_in_oe`=0
  - `addr`=0, `wr_data`=0
  - `mem_wr`=0, `mem_rd`=0
  - FSM=IDLE, `bit_cnt`=0, `mdc_q`=0
- `mem_rd`: high in the `clk` cycle after the `rise` cycle of bit 13.
- `rd_data`: captured in the cycle after `mem_rd`. The MDC half-period ≥2 guarantees capture before the first `fall`.
- `mem_wr`: high in the `clk` cycle after the `rise` cycle of bit 31. `wr_data` and `addr` are stable in that cycle and hold until the next write.
- `mdio_in` / `mdio_in_oe`: update in the cycle after a `fall` cycle, so they are stable a full MDC-low phase before the controller's next rising-edge sample.
- Reset asserted mid-frame: everything returns to reset values in the next cycle; no strobe issues for the partial frame.
- A new ST is accepted on the first `rise` after returning to IDLE (back-to-back frames).

## Structure
- Package `mdio_pkg` holds:
  - the FSM state enum (IDLE, HDR, WTA, WDATA, RTA, RDATA, SKIP)
  - `OP_WRITE`=2'b01, `OP_READ`=2'b10, `ST_CODE`=2'b01
  - `FRAME_BITS`=32, `HDR_LAST`=13
  - This package is shared with the controller.
- Sub-module `mdc_edge_det` produces `rise`/`fall` from `mdc`. Everything else is in one FSM module.
- Target size is ~200 lines of RTL.

## Test plan
- Write frame 0101_00000_00011_10_0xBEEF with `PHY_ADDR`=0 → one `mem_wr` pulse with `addr`=3 and `wr_data`=0xBEEF, 1 clk after the 32nd `rise`.
- Read frame 0110_00000_00101_ZZ with memory returning 0x1234 → `mem_rd` pulse with `addr`=5. `mdio_in` carries 0 (TA), then 0001_0010_0011_0100 over the following `fall`s. `mdio_in_oe` is high for exactly 17 MDC bits.
- Write frame with PHYAD=7 while `PHY_ADDR`=0 → no `mem_wr`, `mdio_in_oe` stays 0, and a following valid frame is accepted.
- ST=00 (first two bits 0,0) → return to IDLE after bit 1. A valid write sent next produces `mem_wr`.
- `reset` pulsed after bit 20 of a write → no `mem_wr`; all outputs at reset values the next cycle.
- Two back-to-back writes (`addr` 1 → 0xAAAA, then `addr` 2 → 0x5555) → two `mem_wr` pulses with correct `addr`/`wr_data`; OP=11 frame → SKIP, no strobe.
